// File: rtl/fake_signal_gen.sv
// Fake ADC pulse injector: passes packed HG/LG words through or substitutes a
// programmable synthetic pulse train on masked channels.
module fake_signal_gen #(
  parameter int NCHAN    = 5,
  parameter int ADC_BITS = 12,
  parameter int LG_SHIFT = 5,
  parameter int CNT_BITS = 32
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        ENABLE,
  input  logic [1:0]                  MODE,
  input  logic [NCHAN-1:0]            CHAN_MASK,
  input  logic [CNT_BITS-1:0]         PERIOD,
  input  logic [CNT_BITS-1:0]         PERIOD2,
  input  logic [15:0]                 PULSE_WIDTH,
  input  logic [ADC_BITS-1:0]         AMPLITUDE,
  input  logic [ADC_BITS-1:0]         PEDESTAL,
  input  logic [7:0]                  BURST_LEN,
  input  logic [NCHAN*2*ADC_BITS-1:0] ADC_IN,
  output logic [NCHAN*2*ADC_BITS-1:0] ADC_OUT,
  output logic                        PULSE_ACTIVE,
  output logic [CNT_BITS-1:0]         PULSE_COUNT
);

  localparam int WORD = 2 * ADC_BITS;
  localparam int WB   = (CNT_BITS > 16) ? CNT_BITS : 16;
  localparam logic [CNT_BITS-1:0] ONE = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] TWO = CNT_BITS'(2);

  logic                  en_d;
  logic [CNT_BITS-1:0]   phase;
  logic [CNT_BITS-1:0]   p_sh, w_sh;
  logic [ADC_BITS-1:0]   amp_sh;
  logic                  ramp_sh;
  logic [ADC_BITS-1:0]   v;
  logic [7:0]            burst_cnt;
  logic                  toggle;

  logic                  mode2_live, phase0, start, ramp_cur;
  logic [CNT_BITS-1:0]   p_raw, p_live, w_live, p_cur, w_cur, phase_next;
  logic [WB-1:0]         width_ext, p_limit;
  logic [ADC_BITS-1:0]   amp_cur, v_next, v_lg, hg, lg;
  logic [ADC_BITS:0]     hg_sum, lg_sum;
  logic [NCHAN*WORD-1:0] out_next;

  // At phase 0 the live inputs are the config for the pulse starting now; the
  // shadow copy carries them for the rest of the period.
  always_comb begin
    mode2_live = (MODE == 2'd2);
    p_raw      = (mode2_live && toggle) ? PERIOD2 : PERIOD;
    p_live     = (p_raw < TWO) ? TWO : p_raw;
    width_ext  = WB'(PULSE_WIDTH);
    p_limit    = WB'(p_live - ONE);
    w_live     = (width_ext < p_limit) ? CNT_BITS'(width_ext) : (p_live - ONE);
    phase0     = (phase == '0);
    p_cur      = phase0 ? p_live : p_sh;
    w_cur      = phase0 ? w_live : w_sh;
    amp_cur    = phase0 ? AMPLITUDE : amp_sh;
    ramp_cur   = phase0 ? (MODE == 2'd1) : ramp_sh;
    start      = phase0 && (w_cur != '0);
    phase_next = (phase == p_cur - ONE) ? '0 : phase + ONE;
    v_next     = '0;
    if (phase < w_cur) begin
      if (ramp_cur) v_next = (v < amp_cur) ? v + ADC_BITS'(1) : amp_cur;
      else          v_next = amp_cur;
    end
  end

  // Saturating sample arithmetic and per-channel substitution.
  always_comb begin
    v_lg     = v >> LG_SHIFT;
    hg_sum   = {1'b0, PEDESTAL} + {1'b0, v};
    lg_sum   = {1'b0, PEDESTAL} + {1'b0, v_lg};
    hg       = hg_sum[ADC_BITS] ? '1 : hg_sum[ADC_BITS-1:0];
    lg       = lg_sum[ADC_BITS] ? '1 : lg_sum[ADC_BITS-1:0];
    out_next = ADC_IN;
    for (int ch = 0; ch < NCHAN; ch++) begin
      if (ENABLE && CHAN_MASK[ch]) out_next[ch*WORD +: WORD] = {hg, lg};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ADC_OUT <= '0;
      en_d    <= 1'b0;
    end else begin
      ADC_OUT <= out_next;
      en_d    <= ENABLE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      phase   <= '0;
      v       <= '0;
      p_sh    <= '0;
      w_sh    <= '0;
      amp_sh  <= '0;
      ramp_sh <= 1'b0;
    end else if (!ENABLE) begin
      phase <= '0;
      v     <= '0;
    end else begin
      phase <= phase_next;
      v     <= v_next;
      if (phase0) begin
        p_sh    <= p_live;
        w_sh    <= w_live;
        amp_sh  <= AMPLITUDE;
        ramp_sh <= (MODE == 2'd1);
      end
    end
  end

  // The count restarts on the first enabled cycle, which is itself a pulse start.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PULSE_COUNT <= '0;
    end else if (ENABLE) begin
      if (!en_d)      PULSE_COUNT <= start ? ONE : '0;
      else if (start) PULSE_COUNT <= PULSE_COUNT + ONE;
    end
  end

  // Period selection reads the old toggle, so a burst's last pulse keeps its spacing.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      burst_cnt <= '0;
      toggle    <= 1'b0;
    end else if (!ENABLE) begin
      burst_cnt <= '0;
      toggle    <= 1'b0;
    end else if (start && mode2_live && (BURST_LEN != 8'd0)) begin
      if (burst_cnt + 8'd1 == BURST_LEN) begin
        burst_cnt <= '0;
        toggle    <= ~toggle;
      end else begin
        burst_cnt <= burst_cnt + 8'd1;
      end
    end
  end

  assign PULSE_ACTIVE = (v != '0);

endmodule

// File: doc/fake_signal_gen.md
Name: fake_signal_gen

Overview:
Parametrised successor to the single-pattern fake ADC injector. Sits between the ADC capture and the filter/trigger modules. Either passes NCHAN packed high-gain/low-gain ADC words through, or replaces selected channels with a synthetic pulse train. Period, width, amplitude, pedestal, shape and burst alternation are run-time programmable.

Parameters:
NCHAN, 5, number of ADC channels
ADC_BITS, 12, bits per gain sample; channel word = 2*ADC_BITS, {HG,LG}
LG_SHIFT, 5, right shift applied to the pulse for the low-gain sample
CNT_BITS, 32, width of period/phase counters

Ports:
CLK  in  1  system clock (120 MHz)
RST_N  in  1  asynchronous active-low reset
ENABLE  in  1  1 = generate fake; 0 = pass-through
MODE  in  2  0 square, 1 ramp, 2 alternating-burst square, 3 reserved (behaves as 0)
CHAN_MASK  in  NCHAN  per-channel substitution enable
PERIOD  in  CNT_BITS  primary pulse spacing, clocks
PERIOD2  in  CNT_BITS  secondary spacing (mode 2)
PULSE_WIDTH  in  16  pulse length, clocks
AMPLITUDE  in  ADC_BITS  pulse height above pedestal, HG counts
PEDESTAL  in  ADC_BITS  baseline added to both gains
BURST_LEN  in  8  pulses per burst before spacing toggles (mode 2)
ADC_IN  in  NCHAN*2*ADC_BITS  packed ADC words, channel 0 in LSBs
ADC_OUT  out  NCHAN*2*ADC_BITS  packed output words
PULSE_ACTIVE  out  1  high while the synthetic pulse is nonzero
PULSE_COUNT  out  CNT_BITS  pulses started since ENABLE rose; wraps

Behaviour:
- Reset (async assert, sync release): ADC_OUT=0, PULSE_ACTIVE=0, PULSE_COUNT=0, phase=0, ramp=0, burst count=0, toggle=0, shadow config=0.
- Shadow config: PERIOD/PERIOD2/PULSE_WIDTH/AMPLITUDE/MODE/BURST_LEN are latched on the first ENABLE cycle and at every phase wrap. Mid-period changes take effect at the next pulse start only. PEDESTAL and CHAN_MASK act immediately.
- Effective period P = PERIOD, or PERIOD2 when mode 2 and toggle=1. If P<2, use P=2.
- Effective width W = min(PULSE_WIDTH, P-1). W=0 gives no pulse, but phase still runs and PULSE_COUNT does not increment.
- Phase counter runs 0..P-1 while ENABLE=1, then wraps to 0. Phase==0 with W>0 is a pulse start: PULSE_COUNT+1.
- Pulse value v, registered:
  - mode 0/2/3: v=AMPLITUDE while phase<W, else 0.
  - mode 1: v increments by 1 per clock while phase<W, saturating at AMPLITUDE; v=0 and ramp resets otherwise.
- PULSE_ACTIVE = (v!=0), same cycle as v.
- Mode 2 bursts: at each pulse start the burst counter increments. When it reaches BURST_LEN, it clears and toggle inverts. BURST_LEN=0 never toggles.
- Sample arithmetic:
  - HG = min(PEDESTAL+v, 2^ADC_BITS-1), computed at ADC_BITS+1 bits then saturated.
  - LG = min(PEDESTAL+(v>>LG_SHIFT), 2^ADC_BITS-1).
  - Word = {HG, LG}.
- Output register, 1 clock latency on every path:
  - ADC_OUT[ch] = ENABLE & CHAN_MASK[ch] ? fake word : ADC_IN[ch].
  - Fake word at cycle n+1 reflects v registered at cycle n, so ADC_OUT lags PULSE_ACTIVE by 1 clock.
- ENABLE falling: the next clock returns all channels to pass-through. Phase, ramp, burst, toggle and v clear. PULSE_COUNT holds.
- ENABLE rising: PULSE_COUNT clears, phase starts at 0, and a pulse starts immediately.
- Simultaneous wrap and config change: the new values are latched and used for the pulse starting that cycle.
- All channels receive an identical fake word; no per-channel offset.

Test Plan:
- RST_N low mid-pulse (ENABLE=1, phase=3) -> ADC_OUT=0, PULSE_ACTIVE=0 immediately (async). After release with ENABLE=1 -> pulse restarts at phase 0.
- ENABLE=0, ADC_IN ch2 = 0xABC123 -> ADC_OUT ch2 = 0xABC123 one clock later; all channels bit-exact.
- Mode 0, PERIOD=10, WIDTH=4, AMP=1847, PED=200, mask=5'b10101:
  - ch0/2/4 show {2047,257} (0x7FF101) for 4 clocks, then {200,200} for 6, repeating.
  - ch1/3 pass through.
  - PULSE_COUNT=3 after 30 clocks.
- Mode 1, WIDTH=8, AMP=5, PED=0 -> HG sequence 1,2,3,4,5,5,5,5,0; LG=0 throughout.
- Mode 2, PERIOD=20, PERIOD2=10, BURST_LEN=3 -> pulse-start spacings 20,20,20,10,10,10,20 and so on.
- Boundaries:
  - PERIOD=0 -> spacing 2, width clamped to 1.
  - WIDTH=0 -> no pulse, PULSE_COUNT stays 0.
  - AMP=4095, PED=100 -> HG saturates at 4095.
  - PERIOD rewritten mid-period -> the old spacing completes first.
